// File: rtl/led_pattern_pkg.sv
// Shared encodings for the LED pattern engine: display modes and bounce direction.
package led_pattern_pkg;

    typedef enum logic [2:0] {
        MODE_SHL    = 3'd0,
        MODE_SHR    = 3'd1,
        MODE_BOUNCE = 3'd2,
        MODE_FLASH  = 3'd3,
        MODE_COUNT  = 3'd4
    } mode_e;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

endpackage

// File: rtl/led_pattern_engine_tick_prescaler.sv
// Step prescaler: free-running counter compared against a speed-scaled terminal count.
module tick_prescaler #(
    parameter int BASE_DIV = 2500000,
    parameter int CNT_W    = $clog2(BASE_DIV * 8)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] speed,
    input  logic       pause,
    output logic       step
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] tc;

    // >= rather than == so a speed reduction below the current count fires at once
    always_comb begin
        tc   = CNT_W'((BASE_DIV << speed) - 1);
        step = !pause && (cnt >= tc);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (!pause) begin
            if (cnt >= tc) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/led_pattern_engine.sv
// LED pattern engine: prescaled steps drive a mode-selectable pattern register.
module led_pattern_engine
    import led_pattern_pkg::*;
#(
    parameter int LED_WIDTH = 16,
    parameter int BASE_DIV  = 2500000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [2:0]           mode,
    input  logic [1:0]           speed,
    input  logic                 pause,
    output logic [LED_WIDTH-1:0] led,
    output logic                 tick,
    output logic [2:0]           active_mode
);

    localparam int CNT_W = $clog2(BASE_DIV * 8);
    localparam logic [LED_WIDTH-1:0] SEED_LSB = LED_WIDTH'(1);
    localparam logic [LED_WIDTH-1:0] SEED_MSB = {1'b1, {(LED_WIDTH-1){1'b0}}};

    logic step;
    dir_e dir;

    tick_prescaler #(
        .BASE_DIV (BASE_DIV),
        .CNT_W    (CNT_W)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .speed (speed),
        .pause (pause),
        .step  (step)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led         <= SEED_LSB;
            tick        <= 1'b0;
            active_mode <= MODE_SHL;
            dir         <= DIR_LEFT;
        end else begin
            tick <= step;
            if (step) begin
                if (mode != active_mode) begin
                    // A mode switch only seeds; the first advance happens on the next step
                    active_mode <= mode;
                    case (mode)
                        MODE_SHL:    led <= SEED_LSB;
                        MODE_SHR:    led <= SEED_MSB;
                        MODE_BOUNCE: begin
                            led <= SEED_LSB;
                            dir <= DIR_LEFT;
                        end
                        MODE_FLASH:  led <= '1;
                        MODE_COUNT:  led <= '0;
                        default:     led <= led;
                    endcase
                end else begin
                    case (active_mode)
                        MODE_SHL:    led <= {led[LED_WIDTH-2:0], led[LED_WIDTH-1]};
                        MODE_SHR:    led <= {led[0], led[LED_WIDTH-1:1]};
                        MODE_BOUNCE: begin
                            // Turn around on the same step so the end LED is lit only once
                            if (dir == DIR_LEFT) begin
                                if (led[LED_WIDTH-1]) begin
                                    dir <= DIR_RIGHT;
                                    led <= led >> 1;
                                end else begin
                                    led <= led << 1;
                                end
                            end else begin
                                if (led[0]) begin
                                    dir <= DIR_LEFT;
                                    led <= led << 1;
                                end else begin
                                    led <= led >> 1;
                                end
                            end
                        end
                        MODE_FLASH:  led <= ~led;
                        MODE_COUNT:  led <= led + LED_WIDTH'(1);
                        default:     led <= led;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_led_pattern_engine.sv
// Scoreboard bench for led_pattern_engine with LED_WIDTH=8, BASE_DIV=4.
module tb_led_pattern_engine;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] mode = 3'd0;
    logic [1:0] speed = 2'd0;
    logic       pause = 1'b0;
    logic [7:0] led;
    logic       tick;
    logic [2:0] active_mode;

    int unsigned total = 0;
    int unsigned bad = 0;
    int unsigned cyc = 0;
    int unsigned rel;

    typedef struct {
        logic [7:0]  led;
        logic [2:0]  amode;
        int unsigned cyc;
    } exp_t;
    exp_t q[$];

    led_pattern_engine #(
        .LED_WIDTH (8),
        .BASE_DIV  (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .mode        (mode),
        .speed       (speed),
        .pause       (pause),
        .led         (led),
        .tick        (tick),
        .active_mode (active_mode)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push(input logic [7:0] l, input logic [2:0] m, input int unsigned c);
        exp_t e;
        e.led = l;
        e.amode = m;
        e.cyc = c;
        q.push_back(e);
    endtask

    // Every tick must match the oldest outstanding expectation, including its cycle
    always @(negedge clk) begin
        if (!reset && tick) begin
            if (q.size() == 0) begin
                check_eq("spurious_tick", 32'(tick), 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check_eq("tick_cyc", cyc, e.cyc);
                check_eq("led", 32'(led), 32'(e.led));
                check_eq("amode", 32'(active_mode), 32'(e.amode));
            end
        end
    end

    task automatic drain(input int unsigned budget);
        int unsigned left;
        left = budget;
        while (q.size() != 0 && left > 0) begin
            @(negedge clk);
            #1;
            left--;
        end
        check_eq("drain_left", q.size(), 32'd0);
        q.delete();
    endtask

    task automatic do_reset(input logic [2:0] m, input logic [1:0] s);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_eq("rst_led", 32'(led), 32'h01);
        check_eq("rst_tick", 32'(tick), 32'd0);
        check_eq("rst_amode", 32'(active_mode), 32'd0);
        mode = m;
        speed = s;
        pause = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        rel = cyc;
    endtask

    logic [7:0] bounce_tab [17] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                    8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02, 8'h04};

    initial begin
        logic [7:0] v;

        // Rotate left from reset
        do_reset(3'd0, 2'd0);
        v = 8'h01;
        for (int k = 1; k <= 9; k++) begin
            v = {v[6:0], v[7]};
            push(v, 3'd0, rel + 4 * k);
        end
        drain(60);

        // Bounce: seed step then walk with single-dwell ends
        do_reset(3'd2, 2'd0);
        for (int k = 0; k < 17; k++) push(bounce_tab[k], 3'd2, rel + 4 * (k + 1));
        drain(100);

        // Mid-period switch to flash is deferred to the next step
        do_reset(3'd0, 2'd0);
        push(8'h02, 3'd0, rel + 4);
        push(8'h04, 3'd0, rel + 8);
        drain(30);
        mode = 3'd3;
        push(8'hFF, 3'd3, rel + 12);
        push(8'h00, 3'd3, rel + 16);
        push(8'hFF, 3'd3, rel + 20);
        push(8'h00, 3'd3, rel + 24);
        @(negedge clk);
        check_eq("hold_led", 32'(led), 32'h04);
        check_eq("hold_amode", 32'(active_mode), 32'd0);
        drain(40);

        // Slow speed, then drop to fastest with cnt=9 already past the new terminal count
        do_reset(3'd0, 2'd2);
        push(8'h02, 3'd0, rel + 16);
        push(8'h04, 3'd0, rel + 32);
        drain(60);
        repeat (9) @(negedge clk);
        speed = 2'd0;
        push(8'h08, 3'd0, rel + 42);
        push(8'h10, 3'd0, rel + 46);
        push(8'h20, 3'd0, rel + 50);
        drain(30);

        // Pause at cnt=2 for 10 cycles
        do_reset(3'd0, 2'd0);
        push(8'h02, 3'd0, rel + 4);
        drain(30);
        repeat (2) @(negedge clk);
        pause = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            check_eq("pause_tick", 32'(tick), 32'd0);
            check_eq("pause_led", 32'(led), 32'h02);
        end
        push(8'h04, 3'd0, rel + 18);
        push(8'h08, 3'd0, rel + 22);
        pause = 1'b0;
        drain(30);

        // Counter through the all-ones wrap, then async reset inside the tick cycle
        do_reset(3'd4, 2'd0);
        for (int k = 1; k <= 257; k++) push(8'(k - 1), 3'd4, rel + 4 * k);
        drain(1100);
        #1;
        reset = 1'b1;
        #1;
        check_eq("async_led", 32'(led), 32'h01);
        check_eq("async_tick", 32'(tick), 32'd0);
        check_eq("async_amode", 32'(active_mode), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        rel = cyc;
        push(8'h00, 3'd4, rel + 4);
        push(8'h01, 3'd4, rel + 8);
        drain(30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/led_pattern_engine.md
Name: led_pattern_engine

Overview:
- Parametrised successor to the fixed 16-LED shift/flash datapath.
- One block contains the tick prescaler, a mode-selectable LED pattern generator, speed scaling and pause.
- Replaces the separate clock divider, shifter, flasher and mux with a single synchronous design on one clock; no derived clocks.
- Sits between the board clock/switch inputs and the LED output pins.

Parameters:
- LED_WIDTH, 16, number of LEDs driven; legal range >= 2.
- BASE_DIV, 2500000, clk cycles per tick at speed=0 (2 Hz at 5 MHz); legal range >= 2.
- CNT_W, $clog2(BASE_DIV*8), prescaler width; derived, not overridden.

Ports:
- clk  input  1  system clock (5 MHz on board).
- reset  input  1  asynchronous, active-high reset.
- mode  input  3  pattern select; encodings in package.
- speed  input  2  tick period = BASE_DIV << speed cycles.
- pause  input  1  1 = freeze the prescaler and pattern.
- led  output  LED_WIDTH  pattern output, registered.
- tick  output  1  one-cycle pulse, high in the cycle the new led value first appears.
- active_mode  output  3  mode currently being displayed.

Behaviour:
- Reset (async assert, sync use after release):
  - cnt = 0, led = 1 (LSB only), tick = 0, active_mode = MODE_SHL, dir = left.
- Prescaler:
  - Terminal count TC = (BASE_DIV << speed) - 1.
  - Each clk with pause=0: if cnt >= TC then cnt <= 0 and a step fires; else cnt <= cnt + 1.
  - pause=1: cnt holds, no step fires, tick = 0.
  - A speed change takes effect immediately. If cnt already >= the new TC, a step fires on the next edge.
- Step (edge where the step fires):
  - led and active_mode update.
  - tick is registered high for exactly the following cycle.
  - Latency from cnt reaching TC to the visible led change is 1 cycle.
- Mode change:
  - If mode != active_mode at a step, then active_mode <= mode and led loads the seed for that mode; no pattern advance that step.
  - Otherwise led advances per the active mode.
  - mode is sampled only at steps; glitches between steps are ignored.
- Modes (seed / advance):
  - MODE_SHL=0: seed 1; rotate left, MSB wraps to LSB.
  - MODE_SHR=1: seed MSB only; rotate right, LSB wraps to MSB.
  - MODE_BOUNCE=2: seed 1 with dir=left.
    - Shift in dir. At bit LED_WIDTH-1 moving left, dir flips and the same step moves to bit LED_WIDTH-2; the LSB end is symmetric.
    - The end LED is lit for exactly one step, with no double dwell.
  - MODE_FLASH=3: seed all ones; invert all bits.
  - MODE_COUNT=4: seed 0; led <= led + 1 modulo 2^LED_WIDTH, wrapping all-ones to 0.
  - Modes 5-7: active_mode takes the value; led holds its current value (no seed load); tick still pulses.
- Simultaneous events:
  - reset dominates everything.
  - pause=1 at the TC edge suppresses the step; it fires on the first unpaused edge.
  - A mode change and a speed change on the same step are both applied.
- Reset mid-operation: all state returns to reset values immediately, and the next step is BASE_DIV<<speed cycles after release.

Decomposition:
- Package led_pattern_pkg holds the mode localparams: MODE_SHL, MODE_SHR, MODE_BOUNCE, MODE_FLASH, MODE_COUNT (3-bit).
- Sub-module tick_prescaler (params BASE_DIV, CNT_W; ports clk, reset, speed, pause, step) owns the counter and TC compare.
- The pattern register, dir flag and mode logic stay in the top module.

Test Plan (BASE_DIV=4, LED_WIDTH=8):
1. Reset release, mode=0, speed=0, pause=0 -> first tick in the 4th cycle after release; led sequence 0x01→0x02→…→0x80→0x01; tick every 4 cycles.
2. mode=2 from reset -> led walks 0x01, 0x02, 0x04 … 0x40, 0x80, then 0x40, 0x20 … 0x02, 0x01, 0x02; no repeated end value.
3. mode switched 0→3 mid-period -> led unchanged until the next tick, then 0xFF, 0x00, 0xFF; active_mode = 3 from that tick.
4. speed=2 (period 16), then speed=0 with cnt=9 -> a step fires on the next edge, then ticks every 4 cycles.
5. pause=1 for 10 cycles at cnt=2 -> cnt and led frozen, tick=0 throughout; after release the step fires 2 cycles later.
6. mode=4 from 0xFE -> 0xFF then 0x00. Then assert reset asynchronously mid-cycle -> led=0x01, tick=0, active_mode=0 without waiting for a clk edge.
